// File: rtl/xor_tree_3x35.sv
// ---------------------------------------------------------------------------
// xor_tree_3x35
//
// Purpose:
//   Folds three packed 35-bit vectors into a single 35-bit word by GF(2)
//   addition (bitwise XOR). This is the summing node of the GF(2^31) PRNG
//   datapath. A two-level combinational XOR tree feeds one output register
//   stage. A valid flag travels alongside the data.
//
// Ports:
//   clk         in   1    rising-edge clock for all state
//   rst_n       in   1    synchronous reset, active low
//   in_valid    in   1    qualifies in_vectors this cycle
//   in_vectors  in   105  vector k at bits [k*35+34 : k*35], vector 0 in LSBs
//   out_xor     out  35   registered XOR of all input vectors
//   out_valid   out  1    out_xor holds the result of a valid input
//
// Handshake:
//   There is no backpressure. An input is accepted on every rising edge
//   where in_valid=1 and rst_n=1. Its result appears on out_xor, with
//   out_valid=1, immediately after that edge, so latency is 1 cycle.
//   When in_valid=0, out_xor keeps its last value and out_valid drops.
// ---------------------------------------------------------------------------
module xor_tree_3x35 #(
  parameter int N_VECTORS = 3,   // tree below is laid out for exactly 3
  parameter int WIDTH     = 35
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [N_VECTORS*WIDTH-1:0]   in_vectors,
  output logic [WIDTH-1:0]             out_xor,
  output logic                         out_valid
);

  // Unpack the three operands.
  logic [WIDTH-1:0] vec0;
  logic [WIDTH-1:0] vec1;
  logic [WIDTH-1:0] vec2;

  assign vec0 = in_vectors[0*WIDTH +: WIDTH];
  assign vec1 = in_vectors[1*WIDTH +: WIDTH];
  assign vec2 = in_vectors[2*WIDTH +: WIDTH];

  // Level 1 pairs v0 with v1. The odd leftover, v2, passes through unchanged.
  logic [WIDTH-1:0] lvl1_pair;
  logic [WIDTH-1:0] lvl1_pass;

  assign lvl1_pair = vec0 ^ vec1;
  assign lvl1_pass = vec2;

  // Level 2 is the root of the tree.
  logic [WIDTH-1:0] tree_root;

  assign tree_root = lvl1_pair ^ lvl1_pass;

  // Output register stage.
  logic [WIDTH-1:0] xor_q;
  logic [WIDTH-1:0] xor_d;
  logic             valid_q;
  logic             valid_d;

  // The data register loads only on a valid input. This keeps idle-cycle
  // garbage (including X) on in_vectors out of out_xor.
  always_comb begin
    xor_d   = xor_q;
    valid_d = in_valid;
    if (in_valid) begin
      xor_d = tree_root;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xor_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      xor_q   <= xor_d;
      valid_q <= valid_d;
    end
  end

  assign out_xor   = xor_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_xor_tree_3x35.sv
// ---------------------------------------------------------------------------
// tb_xor_tree_3x35
//
// Purpose:
//   Self-checking bench for xor_tree_3x35.
//
// How it checks:
//   Driver tasks apply inputs on the falling edge. When an input will be
//   accepted, the driver pushes its expected result onto exp_q. The
//   expected result comes from a per-bit parity model.
//
//   A monitor samples each rising edge. It records what the DUT saw and
//   then checks the outputs 1 time unit later:
//     - on a reset edge, it expects zeros;
//     - after a valid input, it pops exp_q and compares;
//     - after an idle cycle, it expects the last result to be held.
// ---------------------------------------------------------------------------
module tb_xor_tree_3x35;

  localparam int NV = 3;
  localparam int W  = 35;

  // ---------------- clock / reset ----------------
  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [NV*W-1:0] in_vectors;
  logic [W-1:0]    out_xor;
  logic            out_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_vectors = '0;
  end

  xor_tree_3x35 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_vectors (in_vectors),
    .out_xor    (out_xor),
    .out_valid  (out_valid)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_compared = 0;
  int           n_failed   = 0;
  bit           mon_done   = 1'b0;

  // Reference model: each result bit is the parity of the number of
  // vectors that have a 1 in that position.
  function automatic logic [W-1:0] ref_sum(input logic [NV*W-1:0] vecs);
    logic [W-1:0] r;
    int ones;
    r = '0;
    for (int i = 0; i < W; i++) begin
      ones = 0;
      for (int k = 0; k < NV; k++) begin
        if (vecs[k*W + i]) ones++;
      end
      r[i] = (ones % 2) == 1;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand35();
    logic [W-1:0] r;
    r = {$urandom_range(7, 0), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    n_compared++;
    if (act !== req) begin
      n_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_valid(input logic [W-1:0] v0, input logic [W-1:0] v1,
                             input logic [W-1:0] v2);
    @(negedge clk);
    rst_n      = 1'b1;
    in_valid   = 1'b1;
    in_vectors = {v2, v1, v0};
    exp_q.push_back(ref_sum({v2, v1, v0}));
  endtask

  task automatic drive_idle(input bit use_x);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    if (use_x) in_vectors = 'x;
    else       in_vectors = {rand35(), rand35(), rand35()};
  endtask

  // Inputs presented during reset are discarded, so nothing is queued.
  task automatic drive_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_vectors = {rand35(), rand35(), rand35()};
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic         rst_seen;
    logic         vld_seen;
    logic [W-1:0] held;
    logic [W-1:0] exp;
    held = '0;
    while (!mon_done) begin
      @(posedge clk);
      rst_seen = rst_n;
      vld_seen = in_valid;
      #1;
      if (!rst_seen) begin
        check("reset_valid", {{(W-1){1'b0}}, out_valid}, '0);
        check("reset_xor", out_xor, '0);
        held = '0;
      end else if (vld_seen) begin
        check("result_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
        if (exp_q.size() == 0) begin
          n_compared++;
          n_failed++;
          $display("FAIL queue_underrun: no expected entry at %0t", $time);
        end else begin
          exp = exp_q.pop_front();
          check("result_xor", out_xor, exp);
          held = exp;
        end
      end else begin
        check("idle_valid", {{(W-1){1'b0}}, out_valid}, '0);
        check("hold_xor", out_xor, held);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for 2 cycles while in_valid=1 with random data.
    drive_reset();
    drive_reset();

    // Reference vector, checked both by the model and by the known answer.
    drive_valid(35'd9548617438, 35'd14066143831, 35'd7041284509);
    @(posedge clk); #1;
    check("ref_vector", out_xor, 35'd3707600148);

    // Boundaries.
    drive_valid(35'h7FFFFFFFF, 35'h7FFFFFFFF, 35'h7FFFFFFFF);
    drive_valid('0, '0, '0);
    drive_valid(35'h555555555, 35'h555555555, 35'h2AAAAAAAA);

    // Hold: three idle cycles with changing data, one of them all-X.
    drive_idle(1'b0);
    drive_idle(1'b1);
    drive_idle(1'b0);

    // Streaming: 100 back-to-back random valid inputs.
    for (int n = 0; n < 100; n++) begin
      drive_valid(rand35(), rand35(), rand35());
    end

    // Reset mid-stream, then resume streaming.
    for (int n = 0; n < 10; n++) drive_valid(rand35(), rand35(), rand35());
    drive_reset();
    for (int n = 0; n < 10; n++) drive_valid(rand35(), rand35(), rand35());

    // Mixed random valid/idle traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(3, 0) != 0) drive_valid(rand35(), rand35(), rand35());
      else                           drive_idle(1'b0);
    end

    drive_idle(1'b0);
    drive_idle(1'b0);
    @(posedge clk); #2;
    mon_done = 1'b1;
    @(posedge clk); #2;

    // ---------------- final report ----------------
    n_compared++;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xor_tree_3x35.md
Name: xor_tree_3x35

Overview:
- Binary XOR reduction tree that folds 3 packed 35-bit vectors into one 35-bit word.
- Used in the GF(2^31) PRNG datapath wherever several partial products/state terms are summed over GF(2).
- Combinational tree followed by one output register stage, with a valid flag travelling alongside the data.

Parameters:
- N_VECTORS, 3, number of input vectors reduced by the tree (fixed at 3 for this instance).
- WIDTH, 35, bit-length of each vector and of the result.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous reset, active low, sampled on rising clk.
- in_valid  input  1  qualifies in_vectors in the current cycle.
- in_vectors  input  105 (N_VECTORS*WIDTH)  packed vectors; vector k occupies bits [k*35+34 : k*35], vector 0 in the LSBs.
- out_xor  output  35  registered XOR of all vectors.
- out_valid  output  1  high when out_xor holds a result of a valid input.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. No asynchronous reset path.
- Tree structure: level 1 computes v0^v1 while v2 passes through. Level 2 XORs the level-1 result with v2. Tree depth is ceil(log2(N_VECTORS)) = 2. Odd leftovers pass through unchanged to the next level.
- Arithmetic: purely bitwise GF(2) addition. No carries and no width growth; each result bit i = v0[i]^v1[i]^v2[i].
- Result is independent of vector order.
- Latency: exactly 1 clock. in_vectors sampled on rising edge N appears on out_xor after that edge, and out_valid follows the same timing.
- Throughput: one new input per cycle, with no stall or backpressure.
- Register update:
  - out_valid <= in_valid every cycle.
  - out_xor loads the tree result only when in_valid=1.
  - When in_valid=0, out_xor holds its previous value.
- Reset: while rst_n=0 at a rising edge, out_xor <= 0 and out_valid <= 0. Reset overrides in_valid.
- Reset mid-stream: an input presented in the same cycle that rst_n=0 is discarded. After rst_n returns high, the next valid input produces a result 1 cycle later.
- Unknown/X on in_vectors while in_valid=0 must not disturb out_xor.
- No internal state beyond the output registers. Back-to-back valid inputs produce back-to-back results.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and random data -> out_xor=0 and out_valid=0 throughout.
- Reference vector: v2=7041284509, v1=14066143831, v0=9548617438, in_valid=1 -> next cycle out_xor=3707600148, out_valid=1.
- Boundaries:
  - All three vectors = 35'h7FFFFFFFF -> out_xor=35'h7FFFFFFFF.
  - All zeros -> 0.
  - v0=v1=35'h555555555, v2=35'h2AAAAAAAA -> out_xor=35'h2AAAAAAAA (v0 and v1 cancel).
- Hold: valid result, then in_valid=0 with different data for 3 cycles -> out_xor unchanged, out_valid=0.
- Streaming: 100 back-to-back random valid inputs -> each out_xor equals the bitwise XOR of the three vectors from the previous cycle, with out_valid continuously 1.
- Reset mid-stream: assert rst_n=0 for one cycle during streaming -> that cycle's output is 0 with out_valid=0; the following valid input yields the correct XOR 1 cycle later.
